// File: rtl/execute_muldiv_pkg.sv
// Shared encodings and op-decode helpers for the execute-stage multiply/divide unit.
package execute_muldiv_pkg;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned MULDIVOP_LEN = 4;
    localparam int unsigned CNT_W        = 7;
    localparam int unsigned ACC_W        = 2 * XLEN;

    typedef enum logic [MULDIVOP_LEN-1:0] {
        MULDIVOP_MUL    = 4'd0,
        MULDIVOP_MULH   = 4'd1,
        MULDIVOP_MULHSU = 4'd2,
        MULDIVOP_MULHU  = 4'd3,
        MULDIVOP_DIV    = 4'd4,
        MULDIVOP_DIVU   = 4'd5,
        MULDIVOP_REM    = 4'd6,
        MULDIVOP_REMU   = 4'd7,
        MULDIVOP_MULW   = 4'd8,
        MULDIVOP_DIVW   = 4'd9,
        MULDIVOP_DIVUW  = 4'd10,
        MULDIVOP_REMW   = 4'd11,
        MULDIVOP_REMUW  = 4'd12
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Op and result-sign flags latched at start; they steer the final sign fix.
    typedef struct packed {
        muldiv_op_e op;
        logic       neg_res;
        logic       neg_rem;
    } op_flags_t;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op inside {MULDIVOP_DIV, MULDIVOP_DIVU, MULDIVOP_REM, MULDIVOP_REMU,
                          MULDIVOP_DIVW, MULDIVOP_DIVUW, MULDIVOP_REMW, MULDIVOP_REMUW};
    endfunction

    function automatic logic is_rem_op(input muldiv_op_e op);
        return op inside {MULDIVOP_REM, MULDIVOP_REMU, MULDIVOP_REMW, MULDIVOP_REMUW};
    endfunction

    function automatic logic is_w_op(input muldiv_op_e op);
        return op inside {MULDIVOP_MULW, MULDIVOP_DIVW, MULDIVOP_DIVUW,
                          MULDIVOP_REMW, MULDIVOP_REMUW};
    endfunction

    function automatic logic is_high_op(input muldiv_op_e op);
        return op inside {MULDIVOP_MULH, MULDIVOP_MULHSU, MULDIVOP_MULHU};
    endfunction

    function automatic logic signed_a(input muldiv_op_e op);
        return op inside {MULDIVOP_MUL, MULDIVOP_MULH, MULDIVOP_MULHSU, MULDIVOP_DIV,
                          MULDIVOP_REM, MULDIVOP_MULW, MULDIVOP_DIVW, MULDIVOP_REMW};
    endfunction

    function automatic logic signed_b(input muldiv_op_e op);
        return op inside {MULDIVOP_MUL, MULDIVOP_MULH, MULDIVOP_DIV, MULDIVOP_REM,
                          MULDIVOP_MULW, MULDIVOP_DIVW, MULDIVOP_REMW};
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, with one shared sign fix.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned ITER = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [MULDIVOP_LEN-1:0] muldiv_op_i,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic                    flush_i,
    output logic [XLEN-1:0]         result_o,
    output logic                    result_valid_o,
    output logic                    busy_o,
    output logic                    ex_stall_req_valid_o
);

    state_e          state_q;
    state_e          state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [XLEN-1:0]  dsr_q;
    op_flags_t        flags_q;

    muldiv_op_e       op_in;
    logic             w_in;
    logic             sa_in;
    logic             sb_in;
    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  b_ext;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic [ACC_W-1:0] fast_acc;

    logic [XLEN:0]    mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;
    logic [ACC_W-1:0] div_next;
    logic             last_iter;

    logic [ACC_W-1:0] fix_in;
    logic             fix_neg;
    logic [ACC_W-1:0] fix_out;
    logic [XLEN-1:0]  sel;

    // Operand preparation: W-op extension, magnitudes and the two fast paths.
    always_comb begin
        op_in = muldiv_op_e'(muldiv_op_i);
        w_in  = is_w_op(op_in);
        sa_in = signed_a(op_in);
        sb_in = signed_b(op_in);
        a_ext = rs1_data_i;
        b_ext = rs2_data_i;
        if (w_in) begin
            a_ext = sa_in ? {{32{rs1_data_i[31]}}, rs1_data_i[31:0]} : {32'b0, rs1_data_i[31:0]};
            b_ext = sb_in ? {{32{rs2_data_i[31]}}, rs2_data_i[31:0]} : {32'b0, rs2_data_i[31:0]};
        end
        a_neg    = sa_in & a_ext[XLEN-1];
        b_neg    = sb_in & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = sa_in & sb_in & (b_ext == '1) &
                   (a_ext == (w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        fast     = is_div_op(op_in) & (div_zero | div_ovf);
        // Upper half is the remainder, lower half the quotient.
        fast_acc = div_zero ? {a_ext, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_ext};
    end

    // One iteration step for each algorithm.
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_ge   = acc_q[ACC_W-1:XLEN-1] >= {1'b0, dsr_q};
        div_diff = XLEN'(acc_q[ACC_W-1:XLEN-1] - {1'b0, dsr_q});
        div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1} : {acc_q[ACC_W-2:0], 1'b0};
    end

    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    // Shared sign fix and result select; acc_q holds the result until the next start.
    always_comb begin
        fix_in  = acc_q;
        fix_neg = flags_q.neg_res;
        if (is_div_op(flags_q.op)) begin
            if (is_rem_op(flags_q.op)) begin
                fix_in  = {{XLEN{1'b0}}, acc_q[ACC_W-1:XLEN]};
                fix_neg = flags_q.neg_rem;
            end else begin
                fix_in  = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
            end
        end
        fix_out  = fix_neg ? -fix_in : fix_in;
        sel      = is_high_op(flags_q.op) ? fix_out[ACC_W-1:XLEN] : fix_out[XLEN-1:0];
        result_o = is_w_op(flags_q.op) ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (fast) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = is_div_op(op_in) ? ST_DIV : ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_iter) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o               = (state_q != ST_IDLE);
        result_valid_o       = (state_q == ST_DONE);
        ex_stall_req_valid_o = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                               ((state_q == ST_IDLE) && start_i && !fast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!flush_i && ((state_q == ST_MUL) || (state_q == ST_DIV))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Operand capture in IDLE, then one shift step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            dsr_q   <= '0;
            flags_q <= '0;
        end else if (!flush_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        flags_q.op      <= op_in;
                        flags_q.neg_res <= fast ? 1'b0 : (a_neg ^ b_neg);
                        flags_q.neg_rem <= fast ? 1'b0 : a_neg;
                        acc_q           <= fast ? fast_acc : {{XLEN{1'b0}}, a_mag};
                        dsr_q           <= b_mag;
                    end
                end
                ST_MUL:  acc_q <= mul_next;
                ST_DIV:  acc_q <= div_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: directed corner vectors, random ops, flush and reset aborts.
module tb_execute_muldiv;
    import execute_muldiv_pkg::*;

    localparam int unsigned ITER = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  muldiv_op_i;
    logic [63:0] rs1_data_i;
    logic [63:0] rs2_data_i;
    logic        flush_i;
    logic [63:0] result_o;
    logic        result_valid_o;
    logic        busy_o;
    logic        ex_stall_req_valid_o;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [63:0] res;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    execute_muldiv #(.ITER(ITER)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .muldiv_op_i         (muldiv_op_i),
        .rs1_data_i          (rs1_data_i),
        .rs2_data_i          (rs2_data_i),
        .flush_i             (flush_i),
        .result_o            (result_o),
        .result_valid_o      (result_valid_o),
        .busy_o              (busy_o),
        .ex_stall_req_valid_o(ex_stall_req_valid_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from native arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] s1, s2, sq;
        logic signed [31:0] w1, w2, wq;
        logic [127:0]       p;
        logic [31:0]        r32;
        logic               ovf64, ovf32;
        s1 = a; s2 = b; w1 = a[31:0]; w2 = b[31:0];
        r32 = '0; model = '0;
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == '1);
        case (op)
            MULDIVOP_MUL:    model = a * b;
            MULDIVOP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; model = p[127:64]; end
            MULDIVOP_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; model = p[127:64]; end
            MULDIVOP_MULHU:  begin p = {64'b0, a} * {64'b0, b}; model = p[127:64]; end
            MULDIVOP_DIV:    if (b == 0) model = '1; else if (ovf64) model = a;
                             else begin sq = s1 / s2; model = sq; end
            MULDIVOP_DIVU:   model = (b == 0) ? '1 : a / b;
            MULDIVOP_REM:    if (b == 0) model = a; else if (ovf64) model = '0;
                             else begin sq = s1 % s2; model = sq; end
            MULDIVOP_REMU:   model = (b == 0) ? a : a % b;
            MULDIVOP_MULW:   r32 = a[31:0] * b[31:0];
            MULDIVOP_DIVW:   if (w2 == 0) r32 = '1; else if (ovf32) r32 = w1;
                             else begin wq = w1 / w2; r32 = wq; end
            MULDIVOP_DIVUW:  r32 = (w2 == 0) ? '1 : a[31:0] / b[31:0];
            MULDIVOP_REMW:   if (w2 == 0) r32 = w1; else if (ovf32) r32 = '0;
                             else begin wq = w1 % w2; r32 = wq; end
            MULDIVOP_REMUW:  r32 = (w2 == 0) ? a[31:0] : a[31:0] % b[31:0];
            default:         model = '0;
        endcase
        if (op >= 4'd8) model = {{32{r32[31]}}, r32};
    endfunction

    function automatic bit is_fast(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit dv, w, sg, bz, ovf;
        dv  = (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
        w   = (op >= 4'd8);
        sg  = (op == MULDIVOP_DIV) || (op == MULDIVOP_REM) || (op == MULDIVOP_DIVW) || (op == MULDIVOP_REMW);
        bz  = w ? (b[31:0] == 0) : (b == 0);
        ovf = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
        return dv && (bz || ovf);
    endfunction

    // Drive one op at the current cycle T and check the strobe, result and stall profile.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res, input bit fast);
        exp_t        e;
        int unsigned t0;
        int          stall_cnt;
        bit          seen;
        e.res = exp_res;
        e.lat = fast ? 1 : ITER + 1;
        sb.push_back(e);
        start_i = 1'b1; muldiv_op_i = op; rs1_data_i = a; rs2_data_i = b;
        t0 = cyc;
        #1;
        check({tag, "_stall_T"}, 64'(ex_stall_req_valid_o), fast ? 64'd0 : 64'd1);
        step();
        start_i = 1'b0;
        rs1_data_i = {$urandom, $urandom};
        stall_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (result_valid_o) seen = 1'b1;
            else begin
                if (ex_stall_req_valid_o) stall_cnt++;
                step();
            end
        end
        e = sb.pop_front();
        check({tag, "_strobe"}, 64'(result_valid_o), 64'd1);
        if (seen) begin
            check({tag, "_res"}, result_o, e.res);
            check({tag, "_lat"}, 64'(cyc - t0), 64'(e.lat));
            check({tag, "_stall_done"}, 64'(ex_stall_req_valid_o), 64'd0);
            check({tag, "_stall_cycles"}, 64'(stall_cnt), fast ? 64'd0 : 64'(ITER));
            step();
            check({tag, "_one_strobe"}, 64'(result_valid_o), 64'd0);
            check({tag, "_idle"}, 64'(busy_o), 64'd0);
            check({tag, "_hold"}, result_o, e.res);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        int unsigned t0;
        int          strobes;

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        muldiv_op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        repeat (3) step();
        check("rst_result", result_o, 64'd0);
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_stall", 64'(ex_stall_req_valid_o), 64'd0);
        rst = 1'b0;
        step();

        run_op("mul_7x-3", MULDIVOP_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("mulhu_max", MULDIVOP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("divu_zero", MULDIVOP_DIVU, 64'd13, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op("remu_zero", MULDIVOP_REMU, 64'd13, 64'd0, 64'd13, 1'b1);
        run_op("div_ovf", MULDIVOP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1);
        run_op("divw_ovf", MULDIVOP_DIVW, 64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1);
        run_op("remw_-7_2", MULDIVOP_REMW, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("divw_-7_2", MULDIVOP_DIVW, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("mulhsu_-1x2", MULDIVOP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("rem_-100_7", MULDIVOP_REM, -64'sd100, 64'd7, -64'sd2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 12));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = (i % 2 == 0) ? 64'd0 : '1;
            if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
            if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(1, 1000));
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), is_fast(op, a, b));
        end

        // Flush at T+10 of a divide, then a new start at T+11.
        start_i = 1'b1; muldiv_op_i = MULDIVOP_DIV; rs1_data_i = 64'd1000; rs2_data_i = 64'd7;
        t0 = cyc;
        step();
        start_i = 1'b0;
        strobes = 0;
        while (cyc < t0 + 10) begin
            if (result_valid_o) strobes++;
            step();
        end
        flush_i = 1'b1;
        if (result_valid_o) strobes++;
        step();
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_no_strobe", 64'(strobes + int'(result_valid_o)), 64'd0);
        run_op("after_flush", MULDIVOP_MUL, 64'd5, 64'd6, 64'd30, 1'b0);

        // Reset in the middle of a multiply discards it.
        start_i = 1'b1; muldiv_op_i = MULDIVOP_MUL; rs1_data_i = 64'd3; rs2_data_i = 64'd4;
        step();
        start_i = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        strobes = 0;
        for (int i = 0; i < ITER + 8; i++) begin
            if (result_valid_o) strobes++;
            step();
        end
        check("midrst_no_strobe", 64'(strobes), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  system clock, rising-edge.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have port: start_i  input  1  request from execute stage, sampled only in IDLE.
REQ-004 SHALL have port: muldiv_op_i  input  `MULDIVOP_LEN (4)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
REQ-005 SHALL have ports: rs1_data_i, rs2_data_i  input  `XLEN (64)  operands.
REQ-006 SHALL have port: flush_i  input  1  abort the operation in flight.
REQ-007 SHALL have port: result_o  output  64  final result, valid only while result_valid_o=1.
REQ-008 SHALL have port: result_valid_o  output  1  one-cycle result strobe.
REQ-009 SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-010 SHALL have port: ex_stall_req_valid_o  output  1  stall request to the pipeline controller.
REQ-011 SHALL have parameter: ITER, default 64, number of iteration cycles.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-013 SHALL, in IDLE with start_i=1 at cycle T, latch the operand magnitudes, the result signs and the op, then enter MUL or DIV; at T+ITER+1 it SHALL enter DONE.
REQ-014 SHALL hold a 7-bit iteration counter that counts 0..ITER-1 inside MUL/DIV and leaves MUL/DIV at count ITER-1.
REQ-015 SHALL compute MUL* as radix-2 shift-add on unsigned magnitudes into a 128-bit product, followed by a two's-complement sign fix.
- MUL/MULW select product[63:0].
- MULH/MULHSU/MULHU select product[127:64].
REQ-016 SHALL compute DIV* as restoring radix-2 division on magnitudes.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-017 SHALL prepare W-op operands from the low 32 bits: sign-extend for signed ops, zero-extend for unsigned ops. The W-op result SHALL be the low 32 bits, sign-extended to 64.
REQ-018 SHALL treat divisor==0 as a fast path: IDLE->DONE directly, with result at T+1.
- Quotient = all ones (64-bit, or sext of 32 ones for W).
- Remainder = dividend (sext of low 32 for W).
REQ-019 SHALL treat signed overflow (dividend = most-negative at op width, divisor = -1) as a fast path at T+1: quotient = dividend, remainder = 0.
REQ-020 SHALL assert ex_stall_req_valid_o combinationally in IDLE when start_i=1 (excluding the fast path: deasserted), and in MUL/DIV. It SHALL deassert in DONE.
REQ-021 SHALL, in DONE, drive result_valid_o=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL NOT accept a new start in DONE; a start is first accepted on the following IDLE cycle.
REQ-023 SHALL ignore start_i in MUL, DIV and DONE.
REQ-024 SHALL, on flush_i=1 in any state, go to IDLE next cycle with no result_valid_o. flush_i SHALL have priority over start_i and over counter completion.
REQ-025 SHALL keep result_o stable from DONE entry until the next accepted start.

Reset
REQ-026 SHALL, on rst=1 at a clock edge: state=IDLE, counter=0, result_o=0, result_valid_o=0, busy_o=0, ex_stall_req_valid_o=0.
REQ-027 SHALL, on reset mid-operation, discard the operation with no result strobe. rst SHALL have priority over flush_i and start_i.

Structure
REQ-028 SHALL place the MULDIVOP_* encodings, MULDIVOP_LEN and the FSM state encodings in the shared sysconfig.v include.
REQ-029 SHALL be a single module with no sub-modules. The sign-fix SHALL be shared between mul and div via local combinational logic.
REQ-030 SHALL have only these registers: state, counter, 128-bit accumulator/partial remainder, 64-bit multiplicand/divisor, and op/sign flags.

Verification
REQ-031 SHALL cover: MUL 7 x -3, start at T -> result_valid_o at T+65, result 0xFFFFFFFFFFFFFFEB, stall high T..T+64.
REQ-032 SHALL cover: MULHU 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
REQ-033 SHALL cover:
- DIVU 13/0 -> 0xFFFFFFFFFFFFFFFF at T+1.
- REMU 13/0 -> 13 at T+1.
- stall low at T.
REQ-034 SHALL cover:
- DIV 0x8000000000000000/-1 -> 0x8000000000000000.
- DIVW 0xFFFFFFFF80000000/-1 -> 0xFFFFFFFF80000000, fast path.
REQ-035 SHALL cover: REMW -7/2 -> 0xFFFFFFFFFFFFFFFF; DIVW -7/2 -> 0xFFFFFFFFFFFFFFFD.
REQ-036 SHALL cover: DIV started at T, flush_i at T+10 -> busy_o low at T+11, no strobe; a new start at T+11 is accepted.
